mem_port_arbiter: RTL

//  Shares one single-port unified memory between instruction fetch (IF) and data access (MEM).

---
 rtl/riscv_mem_pkg.sv | 23 ++
 rtl/arb_sat_counter.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and constants for the unified memory port arbiter
//
// Purpose: FSM state encoding, transaction owner constants and default bus widths
//          shared by mem_port_arbiter and its bench.
// Ports:   none (package).
package riscv_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef logic owner_t;

    localparam owner_t OWN_IF = 1'b0;
    localparam owner_t OWN_DM = 1'b1;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts inc pulses up to MAX and holds there; clr has priority over inc.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous reset, active-low (count -> 0)
//   inc  in  count up by one unless already at MAX
//   clr  in  force count to 0
//   sat  out count == MAX
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign sat = (cnt_q == MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-port unified memory
//
// Purpose: grants one of the fetch (IF) or data (MEM) requesters, issues a single memory
//          command, waits for read data (with timeout) and returns a one-cycle completion
//          pulse plus held read data to the owner. Stalls hold each stage while its
//          request is outstanding.
// Ports:
//   clk, rst                          clock / synchronous active-low reset
//   if_req, if_addr                   fetch request (level, held until if_valid)
//   if_rdata, if_valid                fetch data and completion pulse
//   dm_req, dm_we, dm_addr, dm_wdata  data request (level, held until dm_valid)
//   dm_rdata, dm_valid                data read data and completion pulse
//   stall_f, stall_m                  pipeline holds
//   mem_req/we/addr/wdata, mem_ready  command channel to memory
//   mem_rvalid, mem_rdata             read return channel from memory
//   err                               sticky read-timeout flag
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;

    logic              grant_dm;
    logic              starve_inc, starve_clr, starve_sat;
    logic              tmo_inc, tmo_clr, tmo_sat;
    logic              resp_load;
    logic [DATA_W-1:0] resp_data;

    // Counts data grants made while a fetch was also waiting.
    arb_sat_counter #(
        .WIDTH (STARVE_W),
        .MAX   (STARVE_MAX)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (starve_sat)
    );

    // Counts WAIT cycles without read data; sat marks the last allowed one.
    arb_sat_counter #(
        .WIDTH (TMO_W),
        .MAX   (TIMEOUT - 1)
    ) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .inc (tmo_inc),
        .clr (tmo_clr),
        .sat (tmo_sat)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        grant_dm   = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        tmo_inc    = 1'b0;
        tmo_clr    = 1'b0;
        resp_load  = 1'b0;
        resp_data  = '0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    // Data has priority unless fetch has been passed over STARVE_MAX times.
                    grant_dm = dm_req && !(if_req && starve_sat);
                    owner_d  = grant_dm ? OWN_DM : OWN_IF;
                    we_d     = grant_dm ? dm_we : 1'b0;
                    addr_d   = grant_dm ? dm_addr : if_addr;
                    wdata_d  = grant_dm ? dm_wdata : '0;
                    if (grant_dm && if_req) begin
                        starve_inc = 1'b1;
                    end else begin
                        starve_clr = 1'b1;
                    end
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (mem_ready) begin
                    if (we_q) begin
                        resp_load = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        tmo_clr = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Read data arriving on the last allowed cycle still counts as success.
                if (mem_rvalid) begin
                    resp_load = 1'b1;
                    resp_data = mem_rdata;
                    state_d   = ST_RESP;
                end else if (tmo_sat) begin
                    resp_load = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only the owner's data register changes so the other side keeps its last value.
        if (resp_load) begin
            if (owner_q == OWN_DM) begin
                dm_rdata_d = resp_data;
            end else begin
                if_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign if_valid  = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign dm_valid  = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = (state_q == ST_CMD);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

    // Nothing is outstanding while reset is held, so the pipeline is not stalled then.
    assign stall_f = rst & if_req & ~if_valid;
    assign stall_m = rst & dm_req & ~dm_valid;

endmodule
